// File: rtl/share_unmask_deserializer.sv
// Collects masked beats of NS shares, XOR-recombines each beat and packs the
// plain bits into a WORD_SIZE word, LSB-first or MSB-first, with a valid/ready handoff.
module share_unmask_deserializer #(
    parameter  int D         = 2,
    parameter  int PAR       = 1,
    parameter  int WORD_SIZE = 64,
    parameter  int REVERSE   = 0,
    localparam int NS        = D + 1,
    localparam int NB        = (WORD_SIZE + PAR - 1) / PAR,
    localparam int CNT_W     = $clog2(NB + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NS*PAR-1:0]    in_shares,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_word,
    output logic [CNT_W-1:0]     beat_cnt
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   word_q, word_d;
    logic [PAR-1:0]         plain;
    logic [31:0]            shamt;
    logic [WORD_SIZE-1:0]   beat_bits;

    function automatic logic [PAR-1:0] unmask(input logic [NS*PAR-1:0] s);
        logic [PAR-1:0] acc;
        acc = '0;
        for (int i = 0; i < NS; i++) begin
            acc = acc ^ s[i*PAR +: PAR];
        end
        return acc;
    endfunction

    assign plain = unmask(in_shares);
    assign shamt = 32'(cnt_q) * 32'(PAR);

    // Plain bits that fall past either end of the word (final partial beat)
    // are shifted out of range and dropped by the truncating cast.
    always_comb begin
        beat_bits = '0;
        if (REVERSE == 0) begin
            beat_bits = WORD_SIZE'({{WORD_SIZE{1'b0}}, plain} << shamt);
        end else begin
            beat_bits = WORD_SIZE'({plain, {WORD_SIZE{1'b0}}} >> (shamt + 32'(PAR)));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    // Word is cleared on entry to COLLECT, so OR-ing acts as a write.
                    word_d = word_q | beat_bits;
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(NB);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    cnt_d   = '0;
                    word_d  = '0;
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
                word_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_word  = word_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_share_unmask_deserializer.sv
// Scoreboarded bench: three PAR=1 / PAR=5 / PAR=64 instances, random masking,
// expected words from a bit-stream packing model, monitors pop on out handshake.
module tb_share_unmask_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Group A: two PAR=1 instances (LSB-first and MSB-first) fed the same stream
    logic        a_valid = 1'b0;
    logic [2:0]  a_shares = '0;
    logic        a_oready = 1'b1;
    logic        a_stall = 1'b0;
    logic        a_rand = 1'b0;
    logic        a0_ready, a0_valid, a1_ready, a1_valid;
    logic [63:0] a0_word, a1_word;
    logic [6:0]  a0_cnt, a1_cnt;

    // Group B: PAR=5, NB=13
    logic        b_valid = 1'b0;
    logic [14:0] b_shares = '0;
    logic        b_oready = 1'b1;
    logic        b_ready, b_ovalid;
    logic [63:0] b_word;
    logic [3:0]  b_cnt;

    // Group C: PAR=64, NB=1
    logic         c_valid = 1'b0;
    logic [191:0] c_shares = '0;
    logic         c_oready = 1'b1;
    logic         c_ready, c_ovalid;
    logic [63:0]  c_word;
    logic [0:0]   c_cnt;

    logic [63:0] qa0[$];
    logic [63:0] qa1[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];

    share_unmask_deserializer #(.D(2), .PAR(1), .WORD_SIZE(64), .REVERSE(0)) u_a0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a0_ready),
        .in_shares(a_shares), .out_valid(a0_valid), .out_ready(a_oready),
        .out_word(a0_word), .beat_cnt(a0_cnt));
    share_unmask_deserializer #(.D(2), .PAR(1), .WORD_SIZE(64), .REVERSE(1)) u_a1 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a1_ready),
        .in_shares(a_shares), .out_valid(a1_valid), .out_ready(a_oready),
        .out_word(a1_word), .beat_cnt(a1_cnt));
    share_unmask_deserializer #(.D(2), .PAR(5), .WORD_SIZE(64), .REVERSE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_shares(b_shares), .out_valid(b_ovalid), .out_ready(b_oready),
        .out_word(b_word), .beat_cnt(b_cnt));
    share_unmask_deserializer #(.D(2), .PAR(64), .WORD_SIZE(64), .REVERSE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready),
        .in_shares(c_shares), .out_valid(c_ovalid), .out_ready(c_oready),
        .out_word(c_word), .beat_cnt(c_cnt));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within cycle bound", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench stopped on timeout");
    endtask

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    // Output-ready drivers; group B is always randomly back-pressured
    always begin
        @(posedge clk);
        #1;
        a_oready = a_stall ? 1'b0 : (a_rand ? 1'($urandom) : 1'b1);
        b_oready = 1'($urandom);
    end

    // Monitors: a word is consumed on each out handshake at the coming edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a0_valid && a_oready) begin
                if (qa0.size() == 0) chk("a0 unexpected word", 1'b1, 1'b0);
                else chk("a0 word", a0_word, qa0.pop_front());
            end
            if (a1_valid && a_oready) begin
                if (qa1.size() == 0) chk("a1 unexpected word", 1'b1, 1'b0);
                else chk("a1 word", a1_word, qa1.pop_front());
            end
            if (b_ovalid && b_oready) begin
                if (qb.size() == 0) chk("b unexpected word", 1'b1, 1'b0);
                else chk("b word", b_word, qb.pop_front());
            end
            if (c_ovalid && c_oready) begin
                if (qc.size() == 0) chk("c unexpected word", 1'b1, 1'b0);
                else chk("c word", c_word, qc.pop_front());
            end
            chk("a0 beat_cnt bound", 64'(a0_cnt > 7'd64), 64'd0);
            chk("b beat_cnt bound", 64'(b_cnt > 4'd13), 64'd0);
        end
    end

    task automatic send_bit_a(input bit b, input bit bubbles);
        int  t;
        bit  acc, x, y;
        if (bubbles) begin
            while ($urandom_range(1, 0) == 1) begin
                a_valid  = 1'b0;
                a_shares = 3'($urandom);
                @(posedge clk);
                #1;
            end
        end
        x = 1'($urandom);
        y = 1'($urandom);
        a_valid  = 1'b1;
        a_shares = {x ^ y ^ b, y, x};
        t = 0;
        forever begin
            @(negedge clk);
            acc = a0_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 2000) timeout_fail("a beat accept");
        end
    endtask

    // stream bit k is beat k; LSB-first packs it at bit k, MSB-first at bit 63-k
    task automatic send_word_a(input logic [63:0] stream, input int nbeats,
                               input bit bubbles, input bit push);
        for (int k = 0; k < nbeats; k++) send_bit_a(stream[k], bubbles);
        a_valid = 1'b0;
        if (push) begin
            qa0.push_back(stream);
            qa1.push_back(rev64(stream));
        end
    endtask

    task automatic send_word_b(input logic [63:0] w, input bit last_top, input bit bubbles);
        logic [64:0] wx;
        logic [4:0]  p, x, y;
        int          t;
        bit          acc;
        wx = {last_top, w};
        for (int k = 0; k < 13; k++) begin
            if (bubbles) begin
                while ($urandom_range(1, 0) == 1) begin
                    b_valid  = 1'b0;
                    b_shares = 15'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            p = wx[k*5 +: 5];
            x = 5'($urandom);
            y = 5'($urandom);
            b_valid  = 1'b1;
            b_shares = {x ^ y ^ p, y, x};
            t = 0;
            forever begin
                @(negedge clk);
                acc = b_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                t++;
                if (t > 2000) timeout_fail("b beat accept");
            end
        end
        b_valid = 1'b0;
        qb.push_back(w);
    endtask

    task automatic send_word_c(input logic [63:0] w);
        logic [63:0] x, y;
        int          t;
        bit          acc;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        c_valid  = 1'b1;
        c_shares = {x ^ y ^ w, y, x};
        t = 0;
        forever begin
            @(negedge clk);
            acc = c_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 2000) timeout_fail("c beat accept");
        end
        c_valid = 1'b0;
        qc.push_back(w);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (qa0.size() != 0 || qa1.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            @(posedge clk);
            t++;
            if (t > 5000) timeout_fail("drain");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] w, w2;
        int          c0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset a0 in_ready", a0_ready, 1'b1);
        chk("reset a0 out_valid", a0_valid, 1'b0);
        chk("reset a0 beat_cnt", a0_cnt, 7'd0);
        chk("reset a0 out_word", a0_word, 64'd0);
        chk("reset b in_ready", b_ready, 1'b1);
        chk("reset b beat_cnt", b_cnt, 4'd0);
        chk("reset c out_valid", c_ovalid, 1'b0);
        @(posedge clk);
        #1;

        // LSB-first stream of w: 64 contiguous beats, valid in cycle 65
        w  = 64'h0123_4567_89AB_CDEF;
        c0 = cyc;
        send_word_a(w, 64, 1'b0, 1'b1);
        chk("lsb latency beats", 64'(cyc - c0), 64'd64);
        chk("lsb out_valid after last beat", a0_valid, 1'b1);
        chk("lsb beat_cnt full", a0_cnt, 7'd64);
        chk("lsb out_word", a0_word, 64'h0123_4567_89AB_CDEF);
        drain();

        // MSB-first: stream bit k = w[63-k]
        send_word_a(rev64(w), 64, 1'b0, 1'b1);
        chk("msb out_word", a1_word, 64'h0123_4567_89AB_CDEF);
        drain();

        // Hold with back-pressure while the next word's first beat waits
        a_stall = 1'b1;
        @(posedge clk);
        #1;
        w  = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        send_word_a(w, 64, 1'b1, 1'b1);
        a_valid  = 1'b1;
        a_shares = {1'b1 ^ w2[0], 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall in_ready low", a0_ready, 1'b0);
            chk("stall out_word stable", a0_word, w);
            chk("stall msb word stable", a1_word, rev64(w));
            chk("stall beat_cnt", a0_cnt, 7'd64);
        end
        a_stall = 1'b0;
        send_word_a(w2, 64, 1'b1, 1'b1);
        drain();

        // Reset after 30 beats discards the partial word
        send_word_a({$urandom, $urandom}, 30, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid reset beat_cnt", a0_cnt, 7'd0);
        chk("mid reset out_word", a0_word, 64'd0);
        chk("mid reset out_valid", a0_valid, 1'b0);
        @(negedge clk);
        chk("mid reset in_ready", a0_ready, 1'b1);
        @(posedge clk);
        #1;
        send_word_a(64'hDEAD_BEEF_0000_FFFF, 64, 1'b0, 1'b1);
        chk("post reset out_word", a0_word, 64'hDEAD_BEEF_0000_FFFF);
        drain();

        // Random gaps and back-pressure over 100 words
        a_rand = 1'b1;
        for (int n = 0; n < 100; n++) send_word_a({$urandom, $urandom}, 64, 1'b1, 1'b1);
        drain();
        a_rand = 1'b0;

        // PAR=5: all-ones with an overflowing last-beat bit
        send_word_b(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) send_word_b({$urandom, $urandom}, 1'($urandom), 1'b1);
        drain();

        // PAR=64: one beat per word
        for (int n = 0; n < 20; n++) send_word_c({$urandom, $urandom});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/share_unmask_deserializer.md
SHARE_UNMASK_DESERIALIZER -- requirements
Module: share_unmask_deserializer

Interface
REQ-001 SHALL have parameter D, default 2, masking order; share count NS = D+1.
REQ-002 SHALL have parameter PAR, default 1, bits per share per beat, legal range 1..64.
REQ-003 SHALL have parameter WORD_SIZE, default 64, width of the recombined word.
REQ-004 SHALL have parameter REVERSE, default 0; 0 = LSB-first fill, 1 = MSB-first fill.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  beat present on in_shares.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready at a clk edge.
REQ-009 SHALL have port in_shares  input  NS*PAR  share i at bits [i*PAR +: PAR].
REQ-010 SHALL have port out_valid  output  1  recombined word available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-012 SHALL have port out_word  output  WORD_SIZE  unmasked word.
REQ-013 SHALL have port beat_cnt  output  clog2(NB+1)  beats accepted for the current word.

Function
REQ-014 SHALL define NB = ceil(WORD_SIZE/PAR) beats per word; LASTW = WORD_SIZE mod PAR, or PAR if zero.
REQ-015 SHALL compute per accepted beat plain = XOR over i of in_shares[i*PAR +: PAR], purely combinationally, no randomness consumed.
REQ-016 SHALL, with REVERSE=0, write beat k (0-based) plain bits into out_word[k*PAR +: PAR]; last beat writes only its low LASTW bits, upper plain bits discarded.
REQ-017 SHALL, with REVERSE=1, write beat k into bits counted from the MSB: out_word[WORD_SIZE-1-k*PAR -: PAR], last beat writing LASTW bits.
REQ-018 SHALL implement FSM states COLLECT and HOLD; reset state COLLECT.
REQ-019 SHALL, in COLLECT: in_ready=1, out_valid=0; each accepted beat increments beat_cnt; accepting beat NB-1 moves to HOLD with beat_cnt=NB.
REQ-020 SHALL, in HOLD: in_ready=0, out_valid=1, out_word stable; on out_ready return to COLLECT, beat_cnt=0.
REQ-021 SHALL give latency of one cycle: out_valid asserts the cycle after the last beat's handshake.
REQ-022 SHALL NOT accept a beat in the same cycle HOLD is left (no bypass); in_ready rises the cycle after the out handshake.
REQ-023 SHALL keep out_word unchanged by in_shares while in HOLD and when in_valid=0.
REQ-024 SHALL clear out_word to zero on the transition HOLD to COLLECT, so partial words contain no stale bits.
REQ-025 SHALL keep in_valid stalls (bubbles) mid-word from altering state or beat_cnt.
REQ-026 SHALL register all outputs or derive them from state only; no combinational path from in_valid/out_ready to in_ready/out_valid.
REQ-027 SHALL handle PAR=64 with WORD_SIZE=64: NB=1, each beat fills a full word.

Reset
REQ-028 SHALL, when rst_n=0 at a clk edge: state=COLLECT, beat_cnt=0, out_word=0, out_valid=0; in_ready=1 from the first cycle after release.
REQ-029 SHALL discard a partially collected word on reset mid-operation; the next word starts at beat 0.
REQ-030 SHALL give reset priority over simultaneous in/out handshakes.

Verification
REQ-031 SHALL cover: D=2,PAR=1; 64 beats with shares (a,b,a^b^w_k) for w=64'h0123_4567_89AB_CDEF, random a,b -> out_valid on cycle 65, out_word=64'h0123_4567_89AB_CDEF.
REQ-032 SHALL cover: same with REVERSE=1, bit k of stream = w[63-k] -> out_word=64'h0123_4567_89AB_CDEF.
REQ-033 SHALL cover: PAR=5 (NB=13, LASTW=4), all-ones plain, last beat plain=5'b11111 -> out_word=64'hFFFF_FFFF_FFFF_FFFF, no overflow bits.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in HOLD with in_valid=1 -> in_ready=0, out_word stable, no beats lost; next word correct after release.
REQ-035 SHALL cover: rst_n pulsed low after 30 of 64 beats, then 64 beats of w=64'hDEAD_BEEF_0000_FFFF -> out_word=64'hDEAD_BEEF_0000_FFFF, beat_cnt=0 after reset.
REQ-036 SHALL cover: random in_valid gaps (50%) over 100 words vs. reference XOR model -> all words match, beat_cnt never exceeds NB.
